// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounce.
//
// Drives a one-hot, active-low column scan and reads the active-low rows
// back through a 2-flop synchronizer. A press is accepted after
// DEBOUNCE_SCANS agreeing sample ticks. It is reported once as
// key_code = row_idx*4 + col_idx, together with a one-clock key_valid
// strobe. A release is accepted after DEBOUNCE_SCANS agreeing ticks.
//
// Parameters:
//   SCAN_DIV       clocks per sample tick (column dwell time), >= 2
//   DEBOUNCE_SCANS agreeing ticks needed to accept a press or a release, >= 1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, one-hot active-low
//   key_code   code of the last accepted key
//   key_valid  one-clock strobe for each accepted press
//   key_held   high while the accepted key remains down
//
// Optional feature: define KEYPAD_REPEAT_EN to enable typematic repeat.
// The first repeat strobe comes after 32 held ticks, and further strobes
// follow every 8 ticks.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  logic [3:0]    row_s1_q, rs_q;
  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    cand_row_q, cand_row_d;
  logic [1:0]    cand_col_q, cand_col_d;
  // Counts agreeing press ticks in DEBOUNCE and release ticks in HELD.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [5:0]    rep_q, rep_d;
`endif

  // Lowest-numbered low row wins (row 0 has the highest priority).
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = 6'd0;
`endif
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (rs_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cand_row_d = low_row(rs_q);
            cand_col_d = col_idx_q;
            cnt_d      = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              // A single agreeing tick is enough; accept immediately.
              key_code_d  = {cand_row_d, cand_col_d};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!rs_q[cand_row_q]) begin
            if (cnt_q == CNT_LAST) begin
              key_code_d  = {cand_row_q, cand_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Bounce: abandon the candidate and resume scanning this tick.
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
      end
      HELD: begin
`ifdef KEYPAD_REPEAT_EN
        rep_d = rep_q;
`endif
        if (tick) begin
          if (rs_q[cand_row_q]) begin
            if (cnt_q == CNT_LAST) begin
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              cnt_d      = '0;
              state_d    = SCAN;
`ifdef KEYPAD_REPEAT_EN
              rep_d      = 6'd0;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Any low reading restarts the release count.
            cnt_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // rep_q == 31 marks the 32nd held tick. Reloading to 24 makes
          // the next strobe come 8 ticks later.
          if (state_d == HELD) begin
            if (rep_q == 6'd31) begin
              key_valid_d = 1'b1;
              rep_d       = 6'd24;
            end else begin
              rep_d = rep_q + 6'd1;
            end
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      rs_q        <= 4'hF;
      div_q       <= '0;
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= 6'd0;
`endif
    end else begin
      row_s1_q    <= row;
      rs_q        <= row_s1_q;
      div_q       <= tick ? '0 : div_q + DW'(1);
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A physical keypad model turns pressed[row][col] into row levels from
// the driven columns. A direct row override is used for tick-exact tests.
// Expected strobes are queued when a press is issued. A monitor pops one
// entry on each key_valid and compares the DUT outputs with it.
module tb_keypad_scanner;
  logic       clk, rst_n;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] code; logic [3:0] col; } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0][3:0] pressed;   // pressed[r][c]
  logic            use_ovr;
  logic [3:0]      row_ovr;
  logic [3:0]      kp_rows;

  always_comb begin
    kp_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col[c]) kp_rows[r] = 1'b0;
  end
  assign row = use_ovr ? row_ovr : kp_rows;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (key_valid) begin
      check("no back-to-back strobe", {31'b0, prev_v}, 0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected strobe: key_code=%0d, none expected", key_code);
      end else begin
        e = q.pop_front();
        check("strobe key_code", {28'b0, key_code}, {28'b0, e.code});
        check("strobe col frozen", {28'b0, col}, {28'b0, e.col});
        check("strobe key_held", {31'b0, key_held}, 1);
      end
    end
    prev_v <= key_valid;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input logic lvl, input int bound, input string name);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (key_held == lvl) begin ok = 1; break; end
    end
    check(name, {31'b0, ok}, 1);
  endtask

  // Returns at the negedge just after col switched to target (a tick edge).
  task automatic align_col(input logic [3:0] target);
    logic [3:0] p;
    bit ok = 0;
    p = col;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (col != p && col == target) begin ok = 1; break; end
      p = col;
    end
    check("align col", {31'b0, ok}, 1);
  endtask

  initial begin
    logic [3:0] prev_col, m;
    int changes, bad, n, c, r0;
    rst_n = 1'b0; use_ovr = 1'b0; row_ovr = 4'hF; pressed = '0;
    wait_n(3);
    // Reset state
    check("reset col", {28'b0, col}, 4'b1110);
    check("reset key_valid", {31'b0, key_valid}, 0);
    check("reset key_held", {31'b0, key_held}, 0);
    check("reset key_code", {28'b0, key_code}, 0);
    rst_n = 1'b1;

    // Idle scan: 40 clks give 10 rotations at 4-clk spacing.
    prev_col = col; changes = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col != prev_col) begin
        changes++;
        if (col != {prev_col[2:0], prev_col[3]}) bad++;
      end
      prev_col = col;
    end
    check("idle rotations", changes, 10);
    check("idle rotation order", bad, 0);
    check("idle key_code", {28'b0, key_code}, 0);

    // Key at row2/col1 -> code 9. It must be held and the column frozen.
    q.push_back('{code: 4'd9, col: 4'b1101});
    pressed[2][1] = 1'b1;
    wait_held(1'b1, 200, "row2col1 held rises");
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (col != 4'b1101 || !key_held) bad++;
    end
    check("row2col1 frozen while held", bad, 0);
    check("row2col1 key_code kept", {28'b0, key_code}, 9);
    pressed = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (!key_held) break;
    end
    check("release latency in window", {31'b0, (n >= 11 && n <= 14)}, 1);
    check("scan resumes at 1011", {28'b0, col}, 4'b1011);

    // Bounce: detect at E+4, agree at E+8, high at E+12 -> no strobe, rotate at E+12.
    use_ovr = 1'b1;
    align_col(4'b1110);
    row_ovr = 4'b1110;
    wait_n(9);
    row_ovr = 4'hF;
    wait_n(2);
    check("bounce col frozen", {28'b0, col}, 4'b1110);
    wait_n(1);
    check("bounce rotates on bounce tick", {28'b0, col}, 4'b1101);
    wait_n(20);

    // Rows 1 and 3 on col3 -> row1 wins, code 7.
    use_ovr = 1'b0;
    q.push_back('{code: 4'd7, col: 4'b0111});
    pressed[1][3] = 1'b1; pressed[3][3] = 1'b1;
    wait_held(1'b1, 200, "row1/3 col3 held rises");
    wait_n(40);
    pressed = '0;
    wait_held(1'b0, 100, "row1/3 col3 held falls");

    // Reset one clock in DEBOUNCE with cnt=2 -> no strobe, reset values.
    use_ovr = 1'b1;
    align_col(4'b1110);
    row_ovr = 4'b1110;
    wait_n(8);
    rst_n = 1'b0; row_ovr = 4'hF;
    wait_n(1);
    check("mid-debounce reset col", {28'b0, col}, 4'b1110);
    check("mid-debounce reset key_code", {28'b0, key_code}, 0);
    check("mid-debounce reset key_held", {31'b0, key_held}, 0);
    check("mid-debounce reset key_valid", {31'b0, key_valid}, 0);
    rst_n = 1'b1;
    wait_n(40);

    // Row1/col0 press with exact latency, then a release bounce (H,H,L,H,H,H).
    q.push_back('{code: 4'd4, col: 4'b1110});
    align_col(4'b1110);
    row_ovr = 4'b1101;
    wait_n(11);
    check("strobe not early", {31'b0, key_valid}, 0);
    wait_n(1);
    check("strobe latency", {31'b0, key_valid}, 1);
    wait_n(1);
    row_ovr = 4'hF;
    wait_n(8);
    row_ovr = 4'b1101;
    wait_n(4);
    row_ovr = 4'hF;
    wait_n(10);
    check("release bounce still held", {31'b0, key_held}, 1);
    wait_n(1);
    check("release bounce held falls", {31'b0, key_held}, 0);
    check("release bounce col rotates", {28'b0, col}, 4'b1101);
    wait_n(20);

    // Random single-column presses through the keypad model.
    use_ovr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      c = $urandom_range(0, 3);
      m = 4'($urandom_range(1, 15));
      r0 = 0;
      while (!m[r0]) r0++;
      q.push_back('{code: 4'(r0 * 4 + c), col: ~(4'b0001 << c)});
      for (int r = 0; r < 4; r++) pressed[r][c] = m[r];
      wait_n(120);
      check("random held", {31'b0, key_held}, 1);
      check("random key_code", {28'b0, key_code}, r0 * 4 + c);
      pressed = '0;
      wait_n(80);
      check("random released", {31'b0, key_held}, 0);
    end

    wait_n(10);
    check("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the display digit ring counter: drives a one-hot, active-low column scan onto a 4x4 matrix keypad and reads the rows back.
- Debounces the reading and emits one 4-bit key code with a single-cycle valid strobe per press.
- Feeds the alarm time-set and control logic; runs on the system clock with an internal sample-rate divider.

Parameters:
- SCAN_DIV, 50000: clock cycles per sample tick, i.e. column dwell time (minimum 2).
- DEBOUNCE_SCANS, 4: consecutive agreeing sample ticks needed to accept a press or a release (minimum 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- row  input  4  keypad rows, active-low (external pull-ups); asynchronous to clk.
- col  output  4  column drive, one-hot active-low.
- key_code  output  4  code of last accepted key, computed as row_idx*4 + col_idx.
- key_valid  output  1  one-clk strobe for each accepted press.
- key_held  output  1  high while an accepted key remains down.

Behaviour:
- Synchronizer: row passes through 2 flops before use. All decisions use the synchronized value rs.
- Divider: counter runs 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1). The divider is free-running outside reset.
- Reset (rst_n=0 at a rising edge):
  - col=4'b1110, col_idx=0, key_code=0, key_valid=0, key_held=0.
  - Divider=0, debounce counter=0, state=SCAN.
  - Reset mid-debounce or mid-hold discards the press; no strobe is issued.
- Column sequence: 1110 -> 1101 -> 1011 -> 0111 -> 1110 (col_idx 0,1,2,3,0). Rotation happens only on a tick, and only in SCAN.
- State SCAN:
  - On tick with rs==4'hF: rotate col.
  - On tick with rs!=4'hF: latch cand_row = index of the lowest-numbered low row (row priority 0>1>2>3), latch cand_col=col_idx, set cnt=1, go to DEBOUNCE. col does not rotate.
- State DEBOUNCE (col frozen):
  - On tick with rs[cand_row]==0: cnt++.
  - When cnt reaches DEBOUNCE_SCANS: key_code <= cand_row*4+cand_col, key_valid=1 for exactly the next clk, key_held=1, go to HELD.
  - On tick with rs[cand_row]==1: go to SCAN and rotate col on that tick; no strobe.
  - DEBOUNCE_SCANS=1: strobe follows the detection tick directly.
- State HELD (col frozen):
  - On tick with rs[cand_row]==1: rel++. On tick with rs[cand_row]==0: rel=0.
  - When rel reaches DEBOUNCE_SCANS: key_held=0, rotate col, go to SCAN.
  - Other keys pressed while in HELD are ignored (no rollover).
- Latency:
  - key_valid rises 1 clk after the DEBOUNCE_SCANS-th agreeing tick.
  - Counting from the detecting tick, that is (DEBOUNCE_SCANS-1)*SCAN_DIV+1 clks.
- key_code holds its value until the next accepted press.
- key_valid is never high for two consecutive clks.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: typematic repeat in HELD.
  - After 32 ticks held, re-strobe key_valid (same key_code), then every 8 ticks.
  - The repeat counter clears on release or reset.
- Undefined: exactly one strobe per press; no repeat logic is synthesized.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_SCANS=3.)
- Reset, rows all high, 40 clks -> col cycles 1110,1101,1011,0111,1110, changing every 4 clks; key_valid stays 0; key_code=0.
- Hold row2 low only while col==1101, stable for 20 ticks -> one key_valid pulse, key_code=9, key_held=1, col frozen at 1101. Then release -> key_held=0 after 3 release ticks, scanning resumes at 1011.
- Row0 low for only 1 tick after detection, then high -> no key_valid; col resumes rotation on the tick the bounce is seen.
- Rows 1 and 3 both low on col3 -> key_code=7 (row1 wins).
- rst_n=0 for 1 clk during DEBOUNCE (cnt=2) -> no strobe; all outputs at reset values; col=1110 on the next clk.
- Release bounce in HELD (high 2 ticks, low 1, high 3) -> key_held falls only after the final 3 high ticks; no second strobe with KEYPAD_REPEAT_EN undefined.
